// File: rtl/xy2_100_rx_pkg.sv
// xy2_pkg: shared XY2-100 frame constants and the receiver state type
package xy2_pkg;
  localparam int XY2_FRAME_BITS = 20;
  localparam logic [2:0] XY2_HDR_16 = 3'b001;
  localparam logic [15:0] XY2_POS_MID = 16'h8000;
  typedef enum logic {HUNT, RECV} state_t;
endpackage

// File: rtl/xy2_100_rx_if.sv
// xy2_100_rx_if: XY2-100 serial link in (xy2_clk/sync/x/y) and position/status out (x_pos, y_pos, pos_valid, frame_err, link_ok, err_cnt)
interface xy2_100_rx_if;
  logic xy2_clk, xy2_sync, xy2_x, xy2_y;
  logic [15:0] x_pos, y_pos;
  logic pos_valid, frame_err, link_ok;
  logic [7:0] err_cnt;
  modport master(output xy2_clk, xy2_sync, xy2_x, xy2_y,
                 input x_pos, y_pos, pos_valid, frame_err, link_ok, err_cnt);
  modport slave(input xy2_clk, xy2_sync, xy2_x, xy2_y,
                output x_pos, y_pos, pos_valid, frame_err, link_ok, err_cnt);
endinterface

// File: rtl/xy2_100_rx_sync_edge.sv
// xy2_sync_edge: 2-flop synchroniser of din (clk, rst_n) with registered rise/fall pulses
module xy2_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);
  logic s1, s2, d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {s1, s2, d, rise, fall} <= '0;
    else begin
      s1 <= din;
      s2 <= s1;
      d <= s2;
      rise <= s2 & ~d;
      fall <= d & ~s2;
    end
endmodule

// File: rtl/xy2_100_rx.sv
// xy2_100_rx: XY2-100 receiver (sys_clk, rst_n, bus slave) delivering checked X/Y positions with link-loss watchdog
module xy2_100_rx
  import xy2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 500,
  parameter logic [15:0] POS_RESET = XY2_POS_MID
) (
  input logic sys_clk,
  input logic rst_n,
  xy2_100_rx_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [4:0] LAST = 5'(XY2_FRAME_BITS - 1);
  state_t state, state_n;
  logic clk_rise, clk_fall, edge_seen, timeout, accept, reject, ovf, ovf_n;
  logic [2:0] ds1, ds2;
  logic [4:0] bit_cnt, bit_cnt_n;
  logic [18:0] sr_x, sr_y, sr_x_n, sr_y_n;
  logic [19:0] fx, fy;
  logic [TW-1:0] tcnt;
  xy2_sync_edge u_clk (.clk(sys_clk), .rst_n, .din(bus.xy2_clk), .rise(clk_rise), .fall(clk_fall));
  assign edge_seen = clk_rise | clk_fall;
  // tcnt rests saturated after reset so the watchdog only arms once the link has been seen
  assign timeout = !edge_seen && tcnt == TW'(TIMEOUT_CYC - 1);
  // ds2 = {sync, x, y}; the bit on the line now is the parity bit when sync is low
  assign fx = {sr_x, ds2[1]};
  assign fy = {sr_y, ds2[0]};
  always_comb begin
    state_n = state;
    bit_cnt_n = bit_cnt;
    ovf_n = ovf;
    sr_x_n = sr_x;
    sr_y_n = sr_y;
    accept = 1'b0;
    reject = 1'b0;
    if (timeout) state_n = HUNT;
    else if (clk_fall) begin
      if (state == HUNT) begin
        if (!ds2[2]) begin
          state_n = RECV;
          bit_cnt_n = '0;
          ovf_n = 1'b0;
        end
      end else if (ds2[2]) begin
        sr_x_n = {sr_x[17:0], ds2[1]};
        sr_y_n = {sr_y[17:0], ds2[0]};
        bit_cnt_n = bit_cnt == LAST ? bit_cnt : bit_cnt + 5'd1;
        ovf_n = ovf | (bit_cnt == LAST);
      end else begin
        accept = bit_cnt == LAST && !ovf && fx[19:17] == XY2_HDR_16 && fy[19:17] == XY2_HDR_16
                 && !(^fx) && !(^fy);
        reject = !accept;
        bit_cnt_n = '0;
        ovf_n = 1'b0;
      end
    end
  end
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      state <= HUNT;
      bit_cnt <= '0;
      ovf <= 1'b0;
      sr_x <= '0;
      sr_y <= '0;
      ds1 <= '0;
      ds2 <= '0;
      tcnt <= TW'(TIMEOUT_CYC);
      bus.link_ok <= 1'b0;
      bus.x_pos <= POS_RESET;
      bus.y_pos <= POS_RESET;
      bus.pos_valid <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.err_cnt <= '0;
    end else begin
      ds1 <= {bus.xy2_sync, bus.xy2_x, bus.xy2_y};
      ds2 <= ds1;
      state <= state_n;
      bit_cnt <= bit_cnt_n;
      ovf <= ovf_n;
      sr_x <= sr_x_n;
      sr_y <= sr_y_n;
      tcnt <= edge_seen ? '0 : tcnt == TW'(TIMEOUT_CYC) ? tcnt : tcnt + TW'(1);
      bus.link_ok <= edge_seen | (bus.link_ok & !timeout);
      bus.pos_valid <= accept | timeout;
      bus.frame_err <= reject;
      if (timeout) begin
        bus.x_pos <= POS_RESET;
        bus.y_pos <= POS_RESET;
      end else if (accept) begin
        bus.x_pos <= fx[16:1];
        bus.y_pos <= fy[16:1];
      end
      if (reject && bus.err_cnt != 8'hFF) bus.err_cnt <= bus.err_cnt + 8'd1;
    end
endmodule
